seg7_scan: RTL and testbench
============================

Name: seg7_scan

Overview:
- Multiplexed 4-digit scan controller. Sits directly upstream of the seg7 hex decoder.
- Takes a 16-bit value and time-multiplexes one nibble per digit slot onto the decoder's 4-bit val input.
- Drives the active-low common anodes. A blanking window at the start of each slot hides the decoder's 1-cycle registered latency and prevents ghosting.
- Value updates are double-buffered and applied only at frame start, so a digit string never tears mid-frame.

Parameters:
- DIGIT_DIV, 100000: clk cycles per digit slot (100 MHz gives 1 kHz slot rate, 250 Hz frame rate). Must be greater than BLANK_CYCLES.
- BLANK_CYCLES, 16: cycles at the start of each slot with all anodes off. Must be ≥2 to cover the seg7 register latency.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- value  in  16  display value; digit 0 (rightmost, an[0]) = value[3:0], digit 3 = value[15:12]
- load  in  1  capture value into shadow register this cycle
- digit_en  in  4  per-digit enable; 0 keeps that anode off for its whole slot
- val  out  4  nibble to seg7 val input, registered
- an  out  4  anode drive, active-low, registered
- frame_tick  out  1  one-cycle pulse at the start of each frame (digit 0 slot)

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - slot_cnt=0, digit=0, shadow=0, disp=0.
  - val=4'h0, an=4'b1111, frame_tick=0.
  - rst mid-slot or mid-frame aborts immediately, with no partial-slot completion.
- Slot timer:
  - slot_cnt counts 0..DIGIT_DIV-1 and wraps.
  - On wrap, digit advances 0→1→2→3→0.
  - The first cycle after reset release is slot_cnt=0, digit=0.
- Per-slot states, decoded from slot_cnt:
  - BLANK: slot_cnt < BLANK_CYCLES; an=4'b1111.
  - DRIVE: slot_cnt ≥ BLANK_CYCLES; an = ~(1<<digit) if digit_en[digit], else 4'b1111.
- Outputs are registered, so the rules above describe the output value in each cycle. Next-state is computed from next slot_cnt/digit, which gives zero extra skew.
- val:
  - Holds disp nibble [4*digit+3 : 4*digit] for the entire slot.
  - Changes on the edge where slot_cnt becomes 0.
  - seg7 output is therefore valid from slot_cnt=1, inside BLANK.
- Shadow buffer:
  - load=1 → shadow<=value on that edge.
  - Back-to-back loads: last one wins.
- Frame boundary (edge where digit goes 3→0, and the first cycle after reset):
  - disp<=shadow, using shadow as it was before that edge.
  - A load on the boundary cycle itself reaches shadow but is shown from the next frame.
  - frame_tick=1 during the cycle with digit=0, slot_cnt=0.
- digit_en:
  - Sampled every cycle, not latched.
  - A change mid-DRIVE takes effect on the following cycle's an.
- Invariants:
  - At most one an bit is low in any cycle.
  - An an bit is never low while slot_cnt < BLANK_CYCLES.

Decomposition:
- Package seg7_pkg holds:
  - NUM_DIGITS=4
  - AN_OFF=4'b1111
  - a digit index typedef (2-bit)
  - a helper function for active-low one-hot anode encoding
- One sub-module, seg7_slot_timer:
  - Contains the slot_cnt/digit counters.
  - Produces slot_start, frame_start and the in_blank flag.
  - Also exposes next-state values so the parent can register val/an aligned.
- The parent holds the shadow/disp buffers and the output registers.

Test Plan (DIGIT_DIV=8, BLANK_CYCLES=2 unless noted):
- Reset release, value never loaded:
  - an=1111 at slot_cnt 0–1, then an=1110 at slot_cnt 2–7.
  - val=0 throughout.
  - frame_tick high only at cycle 0 and every 32 cycles after.
- load with value=16'hBEEF mid-frame (digit 1), digit_en=4'hF:
  - Current frame still shows 0.
  - Next frame shows val=F,E,E,B on an=1110,1101,1011,0111 in successive slots.
- Load at the boundary cycle with value=16'h1234, while shadow=16'h00AA:
  - The next frame shows AA, 00.
  - The frame after that shows 4,3,2,1.
- digit_en=4'b0101:
  - Slots for digits 1 and 3 keep an=1111 for all 8 cycles, while val still steps 0x?.
  - Digits 0 and 2 are driven normally.
- rst asserted at digit 2, slot_cnt=5:
  - Next cycle an=1111, val=0, slot_cnt=0, digit=0.
  - The shadow loaded earlier is cleared, so the display shows 0.
- Invariant check over 10k random load/value/digit_en cycles:
  - Never more than one an bit low.
  - No an bit is low while slot_cnt < 2.
  - val is stable within each slot.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants, digit index type and anode helper for the multiplexed
// 7-segment scan controller.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int VALUE_W    = 4 * NUM_DIGITS;

    localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;

    typedef logic [1:0] digit_t;

    // Active-low one-hot anode pattern selecting a single digit.
    function automatic logic [NUM_DIGITS-1:0] an_onehot(input digit_t d);
        return ~(4'b0001 << d);
    endfunction

endpackage

// File: rtl/seg7_scan_if.sv
// Value/control bundle between a display producer and the scan controller.
// load is a one-cycle qualifier for value: no ready, every load is taken.
interface seg7_scan_if;
    import seg7_pkg::*;

    logic [VALUE_W-1:0]    value;
    logic                  load;
    logic [NUM_DIGITS-1:0] digit_en;
    logic [3:0]            val;
    logic [NUM_DIGITS-1:0] an;
    logic                  frame_tick;

    modport master (
        output value, load, digit_en,
        input  val, an, frame_tick
    );

    modport slave (
        input  value, load, digit_en,
        output val, an, frame_tick
    );

endinterface

// File: rtl/seg7_slot_timer.sv
// Slot/digit counters for the scan controller. All outputs describe the
// coming cycle so the parent can register val/an with no extra skew.
module seg7_slot_timer
    import seg7_pkg::*;
#(
    parameter int DIGIT_DIV    = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic   clk,
    input  logic   rst,
    output digit_t digit_d_o,
    output logic   slot_start_o,
    output logic   frame_start_o,
    output logic   in_blank_o
);

    localparam int            CW        = (DIGIT_DIV > 1) ? $clog2(DIGIT_DIV) : 1;
    localparam logic [CW-1:0] SLOT_LAST = CW'(DIGIT_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

    logic [CW-1:0] slot_cnt_q, slot_cnt_d;
    digit_t        digit_q, digit_d;
    logic          run_q, run_d;

    // run_q holds the counters at 0 for the first post-reset edge so the
    // first running cycle is slot 0 of digit 0 with a fresh frame start.
    always_comb begin
        run_d      = 1'b1;
        slot_cnt_d = slot_cnt_q;
        digit_d    = digit_q;
        if (run_q) begin
            if (slot_cnt_q == SLOT_LAST) begin
                slot_cnt_d = '0;
                digit_d    = digit_q + 2'd1;
            end else begin
                slot_cnt_d = slot_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt_q <= '0;
            digit_q    <= '0;
            run_q      <= 1'b0;
        end else begin
            slot_cnt_q <= slot_cnt_d;
            digit_q    <= digit_d;
            run_q      <= run_d;
        end
    end

    assign digit_d_o     = digit_d;
    assign slot_start_o  = (slot_cnt_d == '0);
    assign frame_start_o = slot_start_o && (digit_d == '0);
    assign in_blank_o    = (slot_cnt_d < BLANK_END);

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed 4-digit scan controller: double-buffered value, one nibble per
// slot onto the seg7 decoder input, active-low anodes with per-slot blanking.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int DIGIT_DIV    = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input logic        clk,
    input logic        rst,
    seg7_scan_if.slave bus
);

    digit_t digit_d;
    logic   slot_start, frame_start, in_blank;

    logic [VALUE_W-1:0]    shadow_q, shadow_d;
    logic [VALUE_W-1:0]    disp_q, disp_d;
    logic [3:0]            val_q, val_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_tick_q, frame_tick_d;

    seg7_slot_timer #(
        .DIGIT_DIV    (DIGIT_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk           (clk),
        .rst           (rst),
        .digit_d_o     (digit_d),
        .slot_start_o  (slot_start),
        .frame_start_o (frame_start),
        .in_blank_o    (in_blank)
    );

    // disp takes the pre-edge shadow, so a load on the boundary cycle itself
    // waits one more frame; val picks up the freshly latched disp directly.
    always_comb begin
        shadow_d     = bus.load ? bus.value : shadow_q;
        disp_d       = frame_start ? shadow_q : disp_q;
        val_d        = slot_start ? disp_d[{digit_d, 2'b00} +: 4] : val_q;
        an_d         = AN_OFF;
        if (!in_blank && bus.digit_en[digit_d]) begin
            an_d = an_onehot(digit_d);
        end
        frame_tick_d = frame_start;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q     <= '0;
            disp_q       <= '0;
            val_q        <= 4'h0;
            an_q         <= AN_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            shadow_q     <= shadow_d;
            disp_q       <= disp_d;
            val_q        <= val_d;
            an_q         <= an_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign bus.val        = val_q;
    assign bus.an         = an_q;
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: directed scenarios plus random load/value/digit_en
// traffic, checked every cycle against a frame/slot model indexed by cycle count.
`timescale 1ns/1ps
module tb_seg7_scan;
    import seg7_pkg::*;

    localparam int DIV   = 8;
    localparam int BLK   = 2;
    localparam int FRAME = DIV * NUM_DIGITS;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg7_scan_if bus();

    seg7_scan #(
        .DIGIT_DIV    (DIV),
        .BLANK_CYCLES (BLK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // scoreboard state
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [15:0] m_shadow;
    logic [15:0] m_disp;
    logic [15:0] pend_val;
    logic        pend_ld;
    logic [3:0]  en_prev;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // Entered #1 after the edge that starts cycle cyc; returns #1 after the next edge.
    task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] en);
        int         sc;
        int         dg;
        logic [3:0] exp_an;
        sc = cyc % DIV;
        dg = (cyc / DIV) % NUM_DIGITS;
        if (cyc % FRAME == 0) m_disp = m_shadow;
        if (pend_ld) m_shadow = pend_val;
        exp_an = 4'hF;
        if (sc >= BLK && en_prev[dg]) exp_an = 4'hF ^ (4'd1 << dg);

        @(negedge clk);
        check("val", 16'(bus.val), (m_disp >> (4 * dg)) & 16'h000F);
        check("an", 16'(bus.an), 16'(exp_an));
        check("frame_tick", 16'(bus.frame_tick), 16'(cyc % FRAME == 0));
        check("an_onehot", 16'($countones(~bus.an) <= 1), 16'd1);
        if (sc < BLK) check("an_blank", 16'(bus.an), 16'h000F);

        bus.load     = ld;
        bus.value    = v;
        bus.digit_en = en;
        pend_ld      = ld;
        pend_val     = v;
        en_prev      = en;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input int n);
        rst      = 1'b1;
        bus.load = 1'b0;
        repeat (n) @(posedge clk);
        @(negedge clk);
        check("rst_an", 16'(bus.an), 16'h000F);
        check("rst_val", 16'(bus.val), 16'h0000);
        check("rst_tick", 16'(bus.frame_tick), 16'h0000);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cyc      = 0;
        m_shadow = 16'h0000;
        m_disp   = 16'h0000;
        pend_ld  = 1'b0;
        en_prev  = bus.digit_en;
    endtask

    initial begin
        bus.load     = 1'b0;
        bus.value    = 16'h0000;
        bus.digit_en = 4'hF;
        pend_ld      = 1'b0;
        pend_val     = 16'h0000;
        m_shadow     = 16'h0000;
        m_disp       = 16'h0000;
        en_prev      = 4'hF;

        do_reset(3);

        // idle after reset: blank/drive pattern on digit 0..3, zeros shown
        repeat (2 * FRAME) step(1'b0, 16'($urandom), 4'hF);

        // mid-frame load while digit 1 is up
        while (cyc % FRAME != DIV + 3) step(1'b0, 16'h0000, 4'hF);
        step(1'b1, 16'hBEEF, 4'hF);
        repeat (2 * FRAME) step(1'b0, 16'($urandom), 4'hF);

        // shadow=00AA, then a load on the frame boundary cycle
        while (cyc % FRAME != 5) step(1'b0, 16'h0000, 4'hF);
        step(1'b1, 16'h00AA, 4'hF);
        while (cyc % FRAME != FRAME - 1) step(1'b0, 16'h0000, 4'hF);
        step(1'b1, 16'h1234, 4'hF);
        repeat (2 * FRAME) step(1'b0, 16'($urandom), 4'hF);

        // back-to-back loads, last one wins; digits 1 and 3 disabled
        step(1'b1, 16'h5A5A, 4'b0101);
        step(1'b1, 16'h9876, 4'b0101);
        repeat (2 * FRAME) step(1'b0, 16'h0000, 4'b0101);

        // reset at digit 2, slot_cnt 5 after a pending load
        step(1'b1, 16'hC0DE, 4'hF);
        while (cyc % FRAME != 2 * DIV + 5) step(1'b0, 16'h0000, 4'hF);
        do_reset(1);
        repeat (2 * FRAME) step(1'b0, 16'h0000, 4'hF);

        // random traffic
        repeat (10000) begin
            step($urandom_range(0, 7) == 0, 16'($urandom),
                 ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
